uart_rx: RTL
============

Name: uart_rx

Overview:
- 8N1 UART receiver; the receive counterpart of the system's UART transmitter.
- Sits on the same CPU peripheral bus as the transmitter, using the same slot style: `valid` qualifies an access, `rd` strobes a read, status is returned in the upper bits of `dout`.
- Oversamples `rxd` with the same bit-time divider as the transmitter.
- Holds one received byte, plus a sticky error flag, until software reads it.

Parameters:
- BIT_TIME, 433, clocks per bit minus 1 (50 MHz / 115200 baud); 12-bit value.
- HALF_TIME, BIT_TIME/2 (216), start-bit mid-point sample offset; integer division.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rxd  in  1  serial input; asynchronous to clk; idle high.
- rd  in  1  read strobe; acts only when valid=1.
- valid  in  1  peripheral select for this cycle.
- dout  out  10  [7:0] received byte, [8] data ready, [9] error (framing or overrun, sticky).

Behaviour:
- Reset, asynchronous on reset_n=0:
  - state=S_IDLE, bit counter=0, divider=0, shift register=0.
  - Both synchronizer flops=1.
  - Holding register=0, ready=0, error=0, dout=10'd0.
- Input sync: rxd passes through 2 flops giving rxd_s; all decisions use rxd_s only.
- Divider tdiv (12-bit):
  - Cleared in S_IDLE and on every state change.
  - Otherwise increments, and wraps to 0 when it reaches its compare value.
- States, 3-bit encoding:
  - S_IDLE: rxd_s=0 → S_START.
  - S_START: at tdiv==HALF_TIME, rxd_s=0 → S_DATA with bitcnt=0; rxd_s=1 → S_IDLE (glitch rejected, nothing reported).
  - S_DATA: at tdiv==BIT_TIME, shift = {rxd_s, shift[7:1]} (LSB first) and bitcnt+1; after the 8th bit → S_STOP.
  - S_STOP: at tdiv==BIT_TIME, rxd_s=1 → byte complete, → S_IDLE. rxd_s=0 → error=1, byte discarded, → S_BREAK.
  - S_BREAK: wait for rxd_s=1, then → S_IDLE. This keeps a held-low line (break) from being decoded as repeated 0x00 frames.
- Sample points: the start bit is checked at its centre, so every data and stop sample lands at bit centre (±1 clk, plus 2 clk sync delay).
- Byte complete, without the FIFO:
  - If ready=0: holding register = shift, ready=1.
  - If ready=1 and no read in the same cycle: the new byte is dropped, error=1 (overrun), the holding register keeps the old byte.
- Read (valid && rd):
  - Clears ready and error at the next edge.
  - A read on a cycle with ready=0 only clears error.
  - Read and byte completion in the same cycle: the new byte is loaded, ready stays 1, no overrun.
- dout is a registered copy of {error, ready, holding}; 1 clk latency after any change.
- Frame latency: ready rises about 9.5 bit times plus 3 clk after the start-bit falling edge at rxd.
- No transmit or auto-baud function.

Optional Feature:
- Macro: UART_RX_FIFO_EN.
- Defined:
  - The holding register is replaced by a 4-entry FIFO (2-bit pointers, 3-bit count).
  - ready = FIFO not empty; dout[7:0] = head entry; a read pops the head.
  - Overrun occurs only when a byte completes with the FIFO full and no same-cycle pop.
  - Push and pop in the same cycle while full: both performed, count unchanged, no error.
  - Wrap-around is by natural 2-bit pointer overflow.
- Undefined: the single-register behaviour above; ports are identical either way.

Decomposition:
- Shared package uart_pkg, also used by the transmitter:
  - BIT_TIME default, derived HALF_TIME.
  - State encodings S_IDLE, S_START, S_DATA, S_STOP, S_BREAK.
  - Status bit indices STAT_READY=8, STAT_ERR=9.
- Sub-module uart_rx_fifo (4x8, push/pop/full/empty), instantiated only under UART_RX_FIFO_EN.
- The synchronizer and state machine stay in uart_rx.

Test Plan:
- Byte 0x55 at 434 clk/bit → ready rises about 4125 clk after the start edge; dout=10'h155; read → dout=10'h055 next cycle.
- Start pulse low for 100 clk, then high → stays in S_IDLE; dout unchanged at 0; no error.
- Byte 0xA3 with the stop bit driven low → dout[9]=1, dout[8]=0. Line held low for 20 bit times produces no further frames; after the line returns high, byte 0x3C is received correctly.
- Overrun, FIFO off: send 0x11, then 0x22 without reading → dout=10'h311; read → 10'h011.
- Overrun, FIFO on: send 0x01..0x05 unread → first read returns 0x01 with dout[9]=1; then 0x02, 0x03, 0x04; 0x05 is lost.
- Reset mid-frame: assert reset_n=0 during bit 4 of 0xF0 → dout=0 immediately; after release, the next full frame 0x9A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// UART shared definitions: bit-time default, FSM state encodings, peripheral status bit indices.
// Used by both the receiver and the transmitter so the two agree on timing and on the status layout.
package uart_pkg;

    localparam logic [11:0] BIT_TIME_DEF = 12'd433;

    localparam int STAT_READY = 8;
    localparam int STAT_ERR   = 9;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } uart_state_e;

    function automatic logic [11:0] half_time(input logic [11:0] bit_time);
        return bit_time >> 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 4x8 receive FIFO; head visible combinationally, push/pop take effect on the next edge.
// A push while full is ignored unless a pop happens in the same cycle; a pop while empty is ignored.
module uart_rx_fifo (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push_i,
    input  logic [7:0] push_dat_i,
    input  logic       pop_i,
    output logic [7:0] head_dat_o,
    output logic       full_o,
    output logic       empty_o
);

    logic [7:0] mem_q [4];
    logic [1:0] wr_ptr_q;
    logic [1:0] rd_ptr_q;
    logic [2:0] cnt_q;
    logic       do_push;
    logic       do_pop;

    assign full_o     = (cnt_q == 3'd4);
    assign empty_o    = (cnt_q == 3'd0);
    assign head_dat_o = mem_q[rd_ptr_q];
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full_o || do_pop);

    // Pointers wrap by plain 2-bit overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) mem_q[i] <= 8'd0;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            cnt_q    <= 3'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= wr_ptr_q + 2'd1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 2'd1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 3'd1;
                2'b01:   cnt_q <= cnt_q - 3'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver on the peripheral bus; dout is registered, 1 clk after any status change.
// rxd cannot be stalled: a byte completing into full storage is dropped and sets the sticky error (UART_RX_FIFO_EN selects 4-deep FIFO).
module uart_rx
    import uart_pkg::*;
#(
    parameter logic [11:0] BIT_TIME = BIT_TIME_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rxd,
    input  logic       rd,
    input  logic       valid,
    output logic [9:0] dout
);

    localparam logic [11:0] HALF_TIME = half_time(BIT_TIME);

    uart_state_e state_q;
    logic        rxd_meta_q;
    logic        rxd_s_q;
    logic [11:0] tdiv_q;
    logic [2:0]  bitcnt_q;
    logic [7:0]  shift_q;
    logic        frame_vld_q;
    logic        frame_err_q;
    logic        err_q;
    logic [9:0]  dout_q;
    logic [9:0]  stat_d;
    logic        rd_en;
    logic        ready_w;
    logic [7:0]  hold_w;
    logic        overrun;

    assign rd_en = valid && rd;
    assign dout  = dout_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_s_q    <= rxd_meta_q;
        end
    end

    // Start bit is re-checked at its centre; every later sample is one full bit time on from there.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            tdiv_q      <= 12'd0;
            bitcnt_q    <= 3'd0;
            shift_q     <= 8'd0;
            frame_vld_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_vld_q <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    tdiv_q <= 12'd0;
                    if (!rxd_s_q) state_q <= S_START;
                end
                S_START: begin
                    if (tdiv_q == HALF_TIME) begin
                        tdiv_q   <= 12'd0;
                        bitcnt_q <= 3'd0;
                        state_q  <= rxd_s_q ? S_IDLE : S_DATA;
                    end else begin
                        tdiv_q <= tdiv_q + 12'd1;
                    end
                end
                S_DATA: begin
                    if (tdiv_q == BIT_TIME) begin
                        tdiv_q  <= 12'd0;
                        shift_q <= {rxd_s_q, shift_q[7:1]};
                        if (bitcnt_q == 3'd7) state_q <= S_STOP;
                        else bitcnt_q <= bitcnt_q + 3'd1;
                    end else begin
                        tdiv_q <= tdiv_q + 12'd1;
                    end
                end
                S_STOP: begin
                    if (tdiv_q == BIT_TIME) begin
                        tdiv_q <= 12'd0;
                        if (rxd_s_q) begin
                            frame_vld_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_BREAK;
                        end
                    end else begin
                        tdiv_q <= tdiv_q + 12'd1;
                    end
                end
                S_BREAK: begin
                    tdiv_q <= 12'd0;
                    if (rxd_s_q) state_q <= S_IDLE;
                end
                default: begin
                    tdiv_q  <= 12'd0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef UART_RX_FIFO_EN
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_head;
    logic       pop;

    assign pop     = rd_en && !fifo_empty;
    assign ready_w = !fifo_empty;
    assign hold_w  = fifo_head;
    assign overrun = frame_vld_q && fifo_full && !pop;

    uart_rx_fifo u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_i     (frame_vld_q),
        .push_dat_i (shift_q),
        .pop_i      (pop),
        .head_dat_o (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );
`else
    logic [7:0] hold_q;
    logic       ready_q;

    assign ready_w = ready_q;
    assign hold_w  = hold_q;
    assign overrun = frame_vld_q && ready_q && !rd_en;

    // A read in the completion cycle frees the slot, so the new byte is taken without overrun.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q  <= 8'd0;
            ready_q <= 1'b0;
        end else if (frame_vld_q && (!ready_q || rd_en)) begin
            hold_q  <= shift_q;
            ready_q <= 1'b1;
        end else if (rd_en) begin
            ready_q <= 1'b0;
        end
    end
`endif

    always_comb begin
        stat_d             = 10'd0;
        stat_d[7:0]        = hold_w;
        stat_d[STAT_READY] = ready_w;
        stat_d[STAT_ERR]   = err_q;
    end

    // A new error in the same cycle as a read wins so it is never silently lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q  <= 1'b0;
            dout_q <= 10'd0;
        end else begin
            err_q  <= (err_q && !rd_en) || frame_err_q || overrun;
            dout_q <= stat_d;
        end
    end

endmodule
